custom_lut_gate: RTL
====================

Name: custom_lut_gate

Overview:
- Parametrised, run-time-programmable successor to the fixed-function custom gates.
- N_IN-input Boolean function held as a 2^N_IN-bit truth table; the table is loaded serially through a ready/valid config port.
- Registered evaluation path: one input vector in, one function bit out, one cycle later.
- Sits wherever the design needs a reconfigurable glue-logic function without re-synthesis.

Parameters:
- N_IN, 3, number of function inputs (1..6).
- INIT, 8'h54, reset truth table; width 2^N_IN; bit k = F(in_vec==k). Default 8'h54 = 1 at minterms 2, 4, 6, i.e. POS of maxterms 0,1,3,5,7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cfg_start  in  1  pulse: begin (or restart) a table load.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_bit  in  1  serial table bit, MSB (index 2^N_IN-1) first.
- cfg_ready  out  1  high in LOAD; a bit is accepted when cfg_valid & cfg_ready.
- cfg_done  out  1  one-cycle pulse on commit of the new table.
- in_valid  in  1  in_vec is valid this cycle.
- in_vec  in  N_IN  function input vector.
- out_valid  out  1  registered in_valid.
- out_f  out  1  registered F(in_vec).
- lut_q  out  2^N_IN  active truth table.

Behaviour:
- Reset values:
  - lut_q = INIT; shadow register = 0; bit count = 0.
  - FSM = IDLE.
  - cfg_ready, cfg_done, out_valid, out_f = 0.
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE: cfg_start goes to LOAD and clears the count.
  - LOAD:
    - cfg_ready = 1.
    - Each accepted bit shifts into the shadow LSB (shadow <= {shadow[W-2:0], cfg_bit}) and increments the count.
    - On acceptance of bit W-1 (W = 2^N_IN), go to COMMIT.
    - cfg_valid low stalls indefinitely; no timeout.
    - cfg_start in LOAD restarts: count cleared, shadow cleared, stays in LOAD. Any bit presented in that same cycle is dropped.
  - COMMIT (one cycle): lut_q <= shadow; cfg_done = 1; cfg_ready = 0; return to IDLE.
  - cfg_start in COMMIT is ignored.
- Evaluation:
  - On each clk: out_valid <= in_valid; if in_valid, out_f <= lut_q[in_vec].
  - When in_valid = 0, out_f holds its previous value.
- Latency: 1 cycle from in_valid to out_valid.
- Throughput: one vector per cycle, including during LOAD.
- Table switch point:
  - Evaluation in the COMMIT cycle uses the old table.
  - The first cycle after COMMIT uses the new table.
  - lut_q never changes during LOAD.
- Reset mid-LOAD aborts the load: table returns to INIT, partial shadow is discarded.
- in_vec is unsigned and used directly as the table index. Every index is in range, so no out-of-range case exists.

Optional Feature:
- Macro: CUSTOM_LUT_READBACK_EN.
- Defined:
  - Extra output rb_bit (1 bit), registered, reset 0.
  - On each accepted cfg bit, rb_bit <= lut_q[W-1-count], so the old table streams out MSB first while the new table streams in (scan-style swap).
  - rb_bit holds its value otherwise.
- Undefined: port and logic are absent; everything else is identical.

Decomposition:
- Package custom_gate_pkg holds:
  - the FSM state enum lut_state_t (IDLE, LOAD, COMMIT), 2-bit encoding;
  - the function lut_width(n) = 1<<n;
  - the constant POS_01357_INIT = 8'h54.
- One natural sub-module: custom_lut_cfg_shift. It holds the FSM, bit counter and shadow shifter, and outputs the shadow, the commit strobe and cfg_ready. The top level owns lut_q and the evaluation register.

Test Plan:
- Reset then sweep in_vec 0..7 with in_valid=1 -> out_f = 0,0,1,0,1,0,1,0, each one cycle later; lut_q = 8'h54.
- Load 8'hE8 (majority function), then sweep -> cfg_done pulses exactly once after the 8th accepted bit; out_f = 0,0,0,1,0,1,1,1.
- Load 8'hFF with cfg_valid toggling every other cycle, in_vec=0 every cycle -> out_f = 0 through the COMMIT cycle and 1 from the next cycle; cfg_ready high only in LOAD.
- Send 5 bits, assert cfg_start, then send 8 bits of 8'h01 -> lut_q = 8'h01; only the final 8 bits count.
- Assert rst after 4 bits of a load -> lut_q = 8'h54, cfg_ready = 0, no cfg_done; a following full load of 8'h96 succeeds.
- With CUSTOM_LUT_READBACK_EN: load 8'h0F over the reset table -> rb_bit sequence 0,1,0,1,0,1,0,0 (8'h54 MSB first).

Source files
------------

// File: rtl/custom_gate_pkg.sv
// -----------------------------------------------------------------------------
// custom_gate_pkg
// Shared types and constants for the programmable custom gate family.
//   lut_state_t     : table-load FSM states (IDLE, LOAD, COMMIT), 2-bit encoding
//   lut_width(n)    : truth-table width for an n-input function (2^n)
//   POS_01357_INIT  : reset table of the legacy gate, 1 at minterms 2, 4, 6
// -----------------------------------------------------------------------------
package custom_gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_state_t;

    function automatic int lut_width(input int n);
        return 1 << n;
    endfunction

    localparam logic [7:0] POS_01357_INIT = 8'h54;

endpackage

// File: rtl/custom_lut_cfg_shift.sv
// -----------------------------------------------------------------------------
// custom_lut_cfg_shift
// Serial truth-table loader: FSM, bit counter and shadow shift register.
// The new table is assembled in the shadow and handed to the owner of the
// active table through a one-cycle commit strobe.
// Optional feature macro: CUSTOM_LUT_READBACK_EN (exports the bit counter).
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   cfg_start     : begin / restart a table load
//   cfg_valid     : cfg_bit valid this cycle
//   cfg_bit       : serial table bit, MSB first
//   cfg_ready     : registered, high exactly while in LOAD
//   commit        : registered one-cycle strobe, high while in COMMIT
//   shadow        : assembled table, valid while commit is high
//   bit_count     : (readback builds only) bits accepted so far in this load
// -----------------------------------------------------------------------------
module custom_lut_cfg_shift
    import custom_gate_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_valid,
    input  logic                       cfg_bit,
    output logic                       cfg_ready,
    output logic                       commit,
    output logic [lut_width(N_IN)-1:0] shadow
`ifdef CUSTOM_LUT_READBACK_EN
    ,
    output logic [N_IN-1:0]            bit_count
`endif
);

    localparam int W = lut_width(N_IN);
    // Counter is N_IN bits wide: it runs 0..W-1 and the last bit is all-ones.
    localparam logic [N_IN-1:0] CNT_LAST = '1;

    lut_state_t      state;
    logic [N_IN-1:0] count;

    // NOTE: state and outputs are registers updated with non-blocking
    // assignments, so every branch below reads the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            shadow    <= '0;
            cfg_ready <= 1'b0;
            commit    <= 1'b0;
        end else begin
            commit <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state     <= LOAD;
                        count     <= '0;
                        cfg_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        // Restart: any bit offered in this cycle is dropped.
                        count  <= '0;
                        shadow <= '0;
                    end else if (cfg_valid) begin
                        shadow <= {shadow[W-2:0], cfg_bit};
                        count  <= count + 1'b1;
                        if (count == CNT_LAST) begin
                            state     <= COMMIT;
                            cfg_ready <= 1'b0;
                            commit    <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    // cfg_start is ignored here; a new load starts from IDLE.
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef CUSTOM_LUT_READBACK_EN
    assign bit_count = count;
`endif

endmodule

// File: rtl/custom_lut_gate.sv
// -----------------------------------------------------------------------------
// custom_lut_gate
// Run-time programmable N_IN-input Boolean function. The truth table (bit k =
// F(in_vec == k)) is loaded serially, MSB first, through a ready/valid port and
// swapped in atomically on commit. Evaluation is registered: one vector per
// cycle, result one cycle later.
// Optional feature macro: CUSTOM_LUT_READBACK_EN adds rb_bit, which streams the
// outgoing table MSB first while the new one streams in.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   cfg_start  : begin / restart a table load
//   cfg_valid  : cfg_bit valid this cycle
//   cfg_bit    : serial table bit, MSB (index 2^N_IN-1) first
//   cfg_ready  : high in LOAD; bit accepted on cfg_valid & cfg_ready
//   cfg_done   : one-cycle pulse on commit of the new table
//   in_valid   : in_vec valid this cycle
//   in_vec     : function input vector (table index)
//   out_valid  : registered in_valid
//   out_f      : registered F(in_vec), holds when in_valid is low
//   lut_q      : active truth table
//   rb_bit     : (readback builds only) old-table bit for each accepted cfg bit
// -----------------------------------------------------------------------------
module custom_lut_gate
    import custom_gate_pkg::*;
#(
    parameter int                         N_IN = 3,
    parameter logic [lut_width(N_IN)-1:0] INIT = POS_01357_INIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_valid,
    input  logic                       cfg_bit,
    output logic                       cfg_ready,
    output logic                       cfg_done,
    input  logic                       in_valid,
    input  logic [N_IN-1:0]            in_vec,
    output logic                       out_valid,
    output logic                       out_f,
    output logic [lut_width(N_IN)-1:0] lut_q
`ifdef CUSTOM_LUT_READBACK_EN
    ,
    output logic                       rb_bit
`endif
);

    localparam int W = lut_width(N_IN);

    logic [W-1:0] shadow;
    logic         commit;
`ifdef CUSTOM_LUT_READBACK_EN
    logic [N_IN-1:0] bit_count;
`endif

    custom_lut_cfg_shift #(
        .N_IN (N_IN)
    ) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .commit    (commit),
        .shadow    (shadow)
`ifdef CUSTOM_LUT_READBACK_EN
        ,
        .bit_count (bit_count)
`endif
    );

    assign cfg_done = commit;

    // Table is loaded at the end of the COMMIT cycle, so evaluation in that
    // cycle still sees the old table and the next cycle sees the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_q <= INIT;
        end else if (commit) begin
            lut_q <= shadow;
        end
    end

    // NOTE: out_f has no else branch but sits in a clocked block, so holding
    // its value infers an enable on the flop, not a latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_f     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_f <= lut_q[in_vec];
            end
        end
    end

`ifdef CUSTOM_LUT_READBACK_EN
    // Accepted bit number `count` pairs with old-table index W-1-count, which
    // for an N_IN-bit counter is simply its bitwise inverse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_bit <= 1'b0;
        end else if (cfg_ready && cfg_valid && !cfg_start) begin
            rb_bit <= lut_q[~bit_count];
        end
    end
`endif

endmodule
